pad_cfg_loader: RTL and testbench
=================================

# pad_cfg_loader

Serial configuration loader that sits directly downstream of the input pads and upstream of the bidirectional pad cells. It receives a three-wire serial frame (SCK/SDI/CSN) arriving raw from input pads and synchronises it into the core clock. It drives the per-pad A/OE/CS/SL/IE/PU/PD control vectors of the bidir pad ring, replacing the tied-off constants. Current configuration is shifted back out on SDO during each frame for readback.

## Interface
- NUM_BIDIR_PADS, 40, number of bidir pads controlled (N); FRAME_W = 7*N derived locally
- clk  in  1  core clock (clk1 domain)
- rst_n  in  1  reset; synchronous, active-low, sampled on rising clk
- cfg_sck  in  1  serial clock from input pad, asynchronous to clk
- cfg_sdi  in  1  serial data from input pad, asynchronous
- cfg_csn  in  1  frame select from input pad, active-low, asynchronous
- cfg_sdo  out  1  readback data, to a bidir pad A input
- bidir_out  out  N  pad A (drive value)
- bidir_oe  out  N  pad output enable
- bidir_cs  out  N  pad Schmitt select
- bidir_sl  out  N  pad slew select
- bidir_ie  out  N  pad input enable
- bidir_pu  out  N  pad pull-up
- bidir_pd  out  N  pad pull-down
- cfg_valid  out  1  one-cycle pulse on each commit
- cfg_err  out  1  sticky error flag

## Operation
- Inputs pass through 2-flop synchronisers, then a third register for edge detection; all decisions use synchronised values.
- Frame layout (shift register sr[FRAME_W-1:0]): field k at sr[k*N +: N], k = 0 out, 1 oe, 2 cs, 3 sl, 4 ie, 5 pu, 6 pd. Host sends MSB first (pd[N-1] first, out[0] last).
- FSM states IDLE, SHIFT, COMMIT.
- IDLE: sync csn falling edge -> SHIFT; sr loaded with active config in the same order; cnt <= 0. SCK edges ignored.
- SHIFT: each sync sck rising edge: sr <= {sr[FRAME_W-2:0], sdi_s}; cnt <= cnt+1, saturating at FRAME_W+1.
- SHIFT, sync csn rising edge: cnt == FRAME_W -> COMMIT; otherwise -> IDLE, cfg_err <= 1, sr discarded, outputs unchanged.
- Same cycle sck rise and csn rise: csn wins, that sck edge is not shifted.
- COMMIT (one cycle): sr copied to output registers; cfg_valid = 1; cfg_err <= 0 unless a pull conflict is found -> IDLE.
- Pull conflict: any pad with pu=pd=1 in sr is committed with pu=pd=0 for that pad only, and cfg_err <= 1; other pads and fields commit normally; cfg_valid still pulses.
- cfg_sdo = sr[FRAME_W-1], combinational from register (first readback bit valid after CSN falls, changes after each accepted sck rise).
- Counter width: clog2(FRAME_W+2).
- Reset values: bidir_out/oe/cs/sl/pu/pd = 0, bidir_ie = all 1, cfg_valid = 0, cfg_err = 0, cfg_sdo = 0, sr = 0, state IDLE. Reset mid-frame aborts the frame with no commit.

## Timing
- Pad-to-action latency: 3 clk cycles from pad transition to the edge being acted on.
- Commit: outputs and cfg_valid change on the clk edge after COMMIT is entered, i.e. 2 cycles after the csn-rise detect cycle; outputs hold until next commit or reset.
- Host constraints: SCK high and low ≥ 4 clk periods each; CSN high ≥ 4 clk periods between frames; SDI stable ≥ 4 clk periods around SCK rise. Violations are not detected.
- cfg_valid is high for exactly one cycle per good or conflict-corrected frame.

## Test plan
- Reset, N=4 (FRAME_W=28): all outputs 0 except bidir_ie = 4'hF; cfg_valid = 0, cfg_err = 0.
- Good frame, 28 bits: pd=0, pu=4'h3, ie=4'hF, sl=0, cs=4'h1, oe=4'hC, out=4'h8 -> one cfg_valid pulse; outputs match exactly; cfg_err = 0.
- Short frame (27 bits) and long frame (29 bits) -> no cfg_valid, outputs unchanged, cfg_err = 1. A following good frame -> cfg_err = 0.
- Readback: after the good frame, send a second frame; cfg_sdo across 28 sck rises returns bits pd[3]..out[0] of the first frame in order.
- Pull conflict: pu = pd = 4'b0101 -> pads 0 and 2 get pu = pd = 0; pads 1 and 3 get pu = pd = 0 as sent; cfg_valid pulses; cfg_err = 1.
- rst_n asserted after 14 sck rises, then released -> outputs return to reset values; a subsequent full frame commits normally. Simultaneous sck rise and csn rise on bit 28 -> frame counted as 27 bits, error.

Source files
------------

// File: rtl/pad_cfg_loader.sv
// pad_cfg_loader: serial (SCK/SDI/CSN) configuration loader for the bidir pad ring.
// Frames are synchronised into clk, shifted through a 7*N bit register and committed
// to the per-pad control vectors. The active configuration is shifted out on SDO
// while a new frame is being received.
module pad_cfg_loader #(
  parameter int NUM_BIDIR_PADS = 40
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_cfg_sck,
  input  logic                      i_cfg_sdi,
  input  logic                      i_cfg_csn,
  output logic                      o_cfg_sdo,
  output logic [NUM_BIDIR_PADS-1:0] o_bidir_out,
  output logic [NUM_BIDIR_PADS-1:0] o_bidir_oe,
  output logic [NUM_BIDIR_PADS-1:0] o_bidir_cs,
  output logic [NUM_BIDIR_PADS-1:0] o_bidir_sl,
  output logic [NUM_BIDIR_PADS-1:0] o_bidir_ie,
  output logic [NUM_BIDIR_PADS-1:0] o_bidir_pu,
  output logic [NUM_BIDIR_PADS-1:0] o_bidir_pd,
  output logic                      o_cfg_valid,
  output logic                      o_cfg_err
);

  localparam int N       = NUM_BIDIR_PADS;
  localparam int FRAME_W = 7 * N;
  localparam int CNT_W   = $clog2(FRAME_W + 2);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_W + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t r_state;
  state_t w_stateNext;

  logic r_sckMeta, r_sckSync, r_sckDly;
  logic r_csnMeta, r_csnSync, r_csnDly;
  logic r_sdiMeta, r_sdiSync;

  logic [FRAME_W-1:0] r_shiftReg;
  logic [CNT_W-1:0]   r_cnt;

  logic [N-1:0] r_out, r_oe, r_cs, r_sl, r_ie, r_pu, r_pd;
  logic         r_cfgValid;
  logic         r_cfgErr;

  logic               w_sckRise;
  logic               w_csnFall;
  logic               w_csnRise;
  logic [FRAME_W-1:0] w_activeCfg;
  logic [N-1:0]       w_srPu;
  logic [N-1:0]       w_srPd;
  logic [N-1:0]       w_pullConflict;

  assign w_sckRise = r_sckSync & ~r_sckDly;
  assign w_csnFall = ~r_csnSync & r_csnDly;
  assign w_csnRise = r_csnSync & ~r_csnDly;

  assign w_activeCfg    = {r_pd, r_pu, r_ie, r_sl, r_cs, r_oe, r_out};
  assign w_srPu         = r_shiftReg[5*N +: N];
  assign w_srPd         = r_shiftReg[6*N +: N];
  assign w_pullConflict = w_srPu & w_srPd;

  // Two-flop synchronisers plus a delay stage so edges are detected on clean values;
  // CSN resets high so releasing reset never looks like a frame start.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sckMeta <= 1'b0;
      r_sckSync <= 1'b0;
      r_sckDly  <= 1'b0;
      r_csnMeta <= 1'b1;
      r_csnSync <= 1'b1;
      r_csnDly  <= 1'b1;
      r_sdiMeta <= 1'b0;
      r_sdiSync <= 1'b0;
    end else begin
      r_sckMeta <= i_cfg_sck;
      r_sckSync <= r_sckMeta;
      r_sckDly  <= r_sckSync;
      r_csnMeta <= i_cfg_csn;
      r_csnSync <= r_csnMeta;
      r_csnDly  <= r_csnSync;
      r_sdiMeta <= i_cfg_sdi;
      r_sdiSync <= r_sdiMeta;
    end
  end

  // Frame state register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state decode; a CSN rise ends the frame and only an exact-length frame commits.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE: begin
        if (w_csnFall) w_stateNext = SHIFT;
      end
      SHIFT: begin
        if (w_csnRise) w_stateNext = (r_cnt == CNT_FULL) ? COMMIT : IDLE;
      end
      COMMIT: begin
        w_stateNext = IDLE;
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // Shift/readback register, bit counter, committed pad controls and status flags.
  // CSN rise is checked before SCK rise so a coincident SCK edge is never shifted.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_shiftReg <= '0;
      r_cnt      <= '0;
      r_out      <= '0;
      r_oe       <= '0;
      r_cs       <= '0;
      r_sl       <= '0;
      r_ie       <= '1;
      r_pu       <= '0;
      r_pd       <= '0;
      r_cfgValid <= 1'b0;
      r_cfgErr   <= 1'b0;
    end else begin
      r_cfgValid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_csnFall) begin
            r_shiftReg <= w_activeCfg;
            r_cnt      <= '0;
          end
        end
        SHIFT: begin
          if (w_csnRise) begin
            if (r_cnt != CNT_FULL) r_cfgErr <= 1'b1;
          end else if (w_sckRise) begin
            r_shiftReg <= {r_shiftReg[FRAME_W-2:0], r_sdiSync};
            if (r_cnt != CNT_SAT) r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        COMMIT: begin
          r_out      <= r_shiftReg[0*N +: N];
          r_oe       <= r_shiftReg[1*N +: N];
          r_cs       <= r_shiftReg[2*N +: N];
          r_sl       <= r_shiftReg[3*N +: N];
          r_ie       <= r_shiftReg[4*N +: N];
          r_pu       <= w_srPu & ~w_pullConflict;
          r_pd       <= w_srPd & ~w_pullConflict;
          r_cfgValid <= 1'b1;
          r_cfgErr   <= |w_pullConflict;
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  assign o_cfg_sdo   = r_shiftReg[FRAME_W-1];
  assign o_bidir_out = r_out;
  assign o_bidir_oe  = r_oe;
  assign o_bidir_cs  = r_cs;
  assign o_bidir_sl  = r_sl;
  assign o_bidir_ie  = r_ie;
  assign o_bidir_pu  = r_pu;
  assign o_bidir_pd  = r_pd;
  assign o_cfg_valid = r_cfgValid;
  assign o_cfg_err   = r_cfgErr;

endmodule

// File: tb/tb_pad_cfg_loader.sv
// tb_pad_cfg_loader: directed frames against pad_cfg_loader with N = 4 (28-bit frames).
// Frame words are written as {pd, pu, ie, sl, cs, oe, out}, one hex digit per field.
module tb_pad_cfg_loader;

  localparam int N = 4;

  localparam logic [27:0] CFG_RESET = 28'h00F0000;
  localparam logic [27:0] CFG_A     = 28'h03F01C8;
  localparam logic [27:0] CFG_C     = 28'h425A639;
  localparam logic [27:0] CFG_X1    = 28'h55F12F6;
  localparam logic [27:0] CFG_X1_OK = 28'h00F12F6;
  localparam logic [27:0] CFG_X2    = 28'hD7F0000;
  localparam logic [27:0] CFG_X2_OK = 28'h82F0000;

  logic         clk;
  logic         rstN;
  logic         cfgSck;
  logic         cfgSdi;
  logic         cfgCsn;
  logic         cfgSdo;
  logic [N-1:0] bidirOut, bidirOe, bidirCs, bidirSl, bidirIe, bidirPu, bidirPd;
  logic         cfgValid;
  logic         cfgErr;

  int checkCount;
  int errorCount;
  int validCount;
  int expValid;

  logic [28:0] readback;

  pad_cfg_loader #(.NUM_BIDIR_PADS(N)) dut (
    .i_clk       (clk),
    .i_rst_n     (rstN),
    .i_cfg_sck   (cfgSck),
    .i_cfg_sdi   (cfgSdi),
    .i_cfg_csn   (cfgCsn),
    .o_cfg_sdo   (cfgSdo),
    .o_bidir_out (bidirOut),
    .o_bidir_oe  (bidirOe),
    .o_bidir_cs  (bidirCs),
    .o_bidir_sl  (bidirSl),
    .o_bidir_ie  (bidirIe),
    .o_bidir_pu  (bidirPu),
    .o_bidir_pd  (bidirPd),
    .o_cfg_valid (cfgValid),
    .o_cfg_err   (cfgErr)
  );

  // 10 ns core clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every cycle cfg_valid is high; a clean run adds exactly one per commit.
  initial validCount = 0;
  always @(negedge clk) begin
    if (cfgValid === 1'b1) validCount = validCount + 1;
  end

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Single comparison point: counts the check and reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount = checkCount + 1;
    if (observed !== expected) begin
      errorCount = errorCount + 1;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Compare every pad control vector against one expected frame word.
  task automatic checkConfig(input string tag, input logic [27:0] exp);
    checkOutput({tag, ".out"}, 32'(bidirOut), 32'(exp[3:0]));
    checkOutput({tag, ".oe"},  32'(bidirOe),  32'(exp[7:4]));
    checkOutput({tag, ".cs"},  32'(bidirCs),  32'(exp[11:8]));
    checkOutput({tag, ".sl"},  32'(bidirSl),  32'(exp[15:12]));
    checkOutput({tag, ".ie"},  32'(bidirIe),  32'(exp[19:16]));
    checkOutput({tag, ".pu"},  32'(bidirPu),  32'(exp[23:20]));
    checkOutput({tag, ".pd"},  32'(bidirPd),  32'(exp[27:24]));
  endtask

  // Host side of one frame: bits[nbits-1] is sent first. SDO is sampled just before
  // each SCK rise. mode 0 = normal end, 1 = last SCK rise coincides with CSN rise,
  // 2 = reset instead of ending the frame.
  task automatic applyStimulus(input logic [28:0] bits, input int nbits, input int mode,
                               output logic [28:0] rb);
    rb = '0;
    cfgCsn = 1'b0;
    waitClk(6);
    for (int i = 0; i < nbits; i++) begin
      cfgSdi = bits[nbits-1-i];
      waitClk(6);
      rb[nbits-1-i] = cfgSdo;
      cfgSck = 1'b1;
      if (mode == 1 && i == nbits - 1) cfgCsn = 1'b1;
      waitClk(6);
      cfgSck = 1'b0;
      waitClk(6);
    end
    if (mode == 2) begin
      rstN   = 1'b0;
      cfgCsn = 1'b1;
      waitClk(5);
      rstN = 1'b1;
      waitClk(6);
    end else begin
      cfgCsn = 1'b1;
      waitClk(10);
    end
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    expValid   = 0;
    rstN   = 1'b0;
    cfgSck = 1'b0;
    cfgSdi = 1'b0;
    cfgCsn = 1'b1;
    waitClk(5);
    rstN = 1'b1;
    waitClk(2);

    $display("[TB] reset state");
    checkConfig("reset", CFG_RESET);
    checkOutput("reset.valid", 32'(cfgValid), 32'd0);
    checkOutput("reset.err",   32'(cfgErr),   32'd0);
    checkOutput("reset.sdo",   32'(cfgSdo),   32'd0);

    $display("[TB] good frame A");
    applyStimulus({1'b0, CFG_A}, 28, 0, readback);
    expValid = expValid + 1;
    checkOutput("A.readback", 32'(readback[27:0]), 32'(CFG_RESET));
    checkConfig("A", CFG_A);
    checkOutput("A.err",   32'(cfgErr), 32'd0);
    checkOutput("A.valid", validCount, expValid);

    $display("[TB] short frame");
    applyStimulus({2'b00, CFG_C[27:1]}, 27, 0, readback);
    checkConfig("short", CFG_A);
    checkOutput("short.err",   32'(cfgErr), 32'd1);
    checkOutput("short.valid", validCount, expValid);

    $display("[TB] good frame A again, readback of A");
    applyStimulus({1'b0, CFG_A}, 28, 0, readback);
    expValid = expValid + 1;
    checkOutput("A2.readback", 32'(readback[27:0]), 32'(CFG_A));
    checkConfig("A2", CFG_A);
    checkOutput("A2.err",   32'(cfgErr), 32'd0);
    checkOutput("A2.valid", validCount, expValid);

    $display("[TB] long frame");
    applyStimulus({CFG_C, 1'b1}, 29, 0, readback);
    checkConfig("long", CFG_A);
    checkOutput("long.err",   32'(cfgErr), 32'd1);
    checkOutput("long.valid", validCount, expValid);

    $display("[TB] good frame C");
    applyStimulus({1'b0, CFG_C}, 28, 0, readback);
    expValid = expValid + 1;
    checkOutput("C.readback", 32'(readback[27:0]), 32'(CFG_A));
    checkConfig("C", CFG_C);
    checkOutput("C.err",   32'(cfgErr), 32'd0);
    checkOutput("C.valid", validCount, expValid);

    $display("[TB] pull conflict pu=pd=0101");
    applyStimulus({1'b0, CFG_X1}, 28, 0, readback);
    expValid = expValid + 1;
    checkOutput("X1.readback", 32'(readback[27:0]), 32'(CFG_C));
    checkConfig("X1", CFG_X1_OK);
    checkOutput("X1.err",   32'(cfgErr), 32'd1);
    checkOutput("X1.valid", validCount, expValid);

    $display("[TB] partial pull conflict pu=0111 pd=1101");
    applyStimulus({1'b0, CFG_X2}, 28, 0, readback);
    expValid = expValid + 1;
    checkConfig("X2", CFG_X2_OK);
    checkOutput("X2.err",   32'(cfgErr), 32'd1);
    checkOutput("X2.valid", validCount, expValid);

    $display("[TB] good frame after conflict");
    applyStimulus({1'b0, CFG_A}, 28, 0, readback);
    expValid = expValid + 1;
    checkOutput("A3.readback", 32'(readback[27:0]), 32'(CFG_X2_OK));
    checkConfig("A3", CFG_A);
    checkOutput("A3.err",   32'(cfgErr), 32'd0);
    checkOutput("A3.valid", validCount, expValid);

    $display("[TB] reset after 14 sck rises");
    applyStimulus({15'd0, CFG_C[27:14]}, 14, 2, readback);
    checkConfig("rst", CFG_RESET);
    checkOutput("rst.err",   32'(cfgErr), 32'd0);
    checkOutput("rst.sdo",   32'(cfgSdo), 32'd0);
    checkOutput("rst.valid", validCount, expValid);

    $display("[TB] full frame after reset");
    applyStimulus({1'b0, CFG_A}, 28, 0, readback);
    expValid = expValid + 1;
    checkOutput("A4.readback", 32'(readback[27:0]), 32'(CFG_RESET));
    checkConfig("A4", CFG_A);
    checkOutput("A4.err",   32'(cfgErr), 32'd0);
    checkOutput("A4.valid", validCount, expValid);

    $display("[TB] sck rise coincident with csn rise on bit 28");
    applyStimulus({1'b0, CFG_C}, 28, 1, readback);
    checkConfig("simul", CFG_A);
    checkOutput("simul.err",   32'(cfgErr), 32'd1);
    checkOutput("simul.valid", validCount, expValid);

    $display("[TB] Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
